serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/full_adder_structural.sv | 28 ++
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_structural.sv
// ============================================================================
// Module   : full_adder_structural
// Brief    : Gate-level one-bit full adder (per-bit datapath of serial_adder).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_structural (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output wire logic s,
    output wire logic cout
);

    wire logic w_axb;
    wire logic w_ab;
    wire logic w_cab;

    xor g_x0 (w_axb, a, b);
    xor g_x1 (s, w_axb, cin);
    and g_a0 (w_ab, a, b);
    and g_a1 (w_cab, w_axb, cin);
    or  g_o0 (cout, w_ab, w_cab);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, LSB first, one full adder per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ADD   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam int         c_CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_fa_s;
    logic               w_fa_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_sh;

    full_adder_structural u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    assign w_last   = (r_cnt == c_CNT_W'(WIDTH - 1));
    // Accumulator holds WIDTH-1 bits; the final bit completes the sum directly.
    assign w_acc_sh = {w_fa_s, r_acc};

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_ADD;
            c_ADD:   if (w_last) w_next = c_DONE;
            c_DONE:  w_next = start ? c_ADD : c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_carry <= cin;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                c_ADD: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_fa_c;
                    r_acc   <= w_acc_sh[WIDTH-1:1];
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    // Result registers change only at completion so they stay
                    // stable through IDLE and the following operation.
                    if (w_last) begin
                        r_sum  <= w_acc_sh;
                        r_cout <= w_fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == c_ADD);
        done = (r_state == c_DONE);
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder (WIDTH=8) against a
//            cycle-countdown arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    wire          busy;
    wire          done;
    wire  [W-1:0] sum;
    wire          cout;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is a countdown of W cycles ending in one done cycle.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [W:0] m_tot  = '0;
    logic [W-1:0] m_sum = '0;
    logic       m_cout = 1'b0;
    bit         m_init = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_init <= 1'b1;
        end else if (m_left == 0 && start) begin
            m_tot  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_left <= W;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_sum  <= m_tot[W-1:0];
                m_cout <= m_tot[W];
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    logic         p_done  = 1'b0;
    logic         p_quiet = 1'b0;
    logic         p_reset = 1'b1;
    logic [W-1:0] p_sum   = '0;
    logic         p_cout  = 1'b0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            if (m_left == 0) begin
                chk("sum", {24'd0, sum}, {24'd0, m_sum});
                chk("cout", {31'd0, cout}, {31'd0, m_cout});
            end
            chk("busy_and_done", {31'd0, busy & done}, 32'd0);
            if (p_done) chk("done_single_cycle", {31'd0, done}, 32'd0);
            if (p_quiet && !busy && !done && !p_reset) begin
                chk("idle_sum_stable", {24'd0, sum}, {24'd0, p_sum});
                chk("idle_cout_stable", {31'd0, cout}, {31'd0, p_cout});
            end
            p_done  <= done;
            p_quiet <= !busy;
            p_sum   <= sum;
            p_cout  <= cout;
        end
        p_reset <= reset;
    end

    // Runs one operation; lat counts negedges from the accept edge to done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, output int lat, output int nbusy);
        @(posedge clk); #2;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin lat = i; break; end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, nb;
    logic [W:0] r_exp;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum",  {24'd0, sum},  32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        #1 reset = 1'b0;

        run_op(8'h5A, 8'hA5, 1'b0, lat, nb);
        chk("lat_5A_A5", lat, 9);
        chk("busy_cycles_5A_A5", nb, 8);
        chk("sum_5A_A5", {24'd0, sum}, 32'hFF);
        chk("cout_5A_A5", {31'd0, cout}, 32'd0);

        run_op(8'hFF, 8'h01, 1'b0, lat, nb);
        chk("sum_FF_01", {24'd0, sum}, 32'h00);
        chk("cout_FF_01", {31'd0, cout}, 32'd1);
        run_op(8'hFF, 8'hFF, 1'b1, lat, nb);
        chk("sum_FF_FF_1", {24'd0, sum}, 32'hFF);
        chk("cout_FF_FF_1", {31'd0, cout}, 32'd1);

        // start held high; operands corrupted during ADD; back-to-back in DONE
        repeat (2) @(posedge clk); #2;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = 8'hEE; b = 8'hEE;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        chk("lat_held_start", lat, 9);
        chk("sum_10_20", {24'd0, sum}, 32'h30);
        chk("cout_10_20", {31'd0, cout}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        #1 start = 1'b0;
        chk("lat_back_to_back", lat, 9);
        chk("sum_EE_EE", {24'd0, sum}, 32'hDC);
        chk("cout_EE_EE", {31'd0, cout}, 32'd1);

        // reset on ADD cycle 4
        repeat (2) @(posedge clk); #2;
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum",  {24'd0, sum},  32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        #1 reset = 1'b0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nb++;
        end
        chk("abort_no_done", nb, 0);
        run_op(8'h03, 8'h04, 1'b0, lat, nb);
        chk("sum_03_04", {24'd0, sum}, 32'h07);

        // reset and start together: reset wins
        @(posedge clk); #2;
        reset = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        chk("reset_priority_busy", {31'd0, busy}, 32'd0);
        #1 reset = 1'b0; start = 1'b0;

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            r_exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, lat, nb);
            chk("rand_sum", {24'd0, sum}, {24'd0, r_exp[W-1:0]});
            chk("rand_cout", {31'd0, cout}, {31'd0, r_exp[W]});
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
